// File: rtl/sysref_phase_mon.sv
// SYSREF phase monitor: reports the phase of each SYSREF rising edge against a
// free-running modulo-SYSREF_PERIOD counter and tracks SYSREF periodicity.
module sysref_phase_mon #(
  parameter int unsigned SYSREF_PERIOD = 48,
  parameter int unsigned LOCK_COUNT    = 4
) (
  input  logic        aclk_i,
  input  logic        aclk_rstn_i,
  input  logic        sysref_i,
  input  logic        align_i,
  input  logic        clear_i,
  output logic [15:0] sysref_phase_o,
  output logic        sysref_edge_o
);
  localparam logic [7:0] PERIOD   = 8'(SYSREF_PERIOD);
  localparam logic [7:0] CNT_LAST = 8'(SYSREF_PERIOD - 1);
  localparam logic [3:0] LOCK     = 4'(LOCK_COUNT);

  logic       s_q;
  logic       edge_q;
  logic       armed;
  logic       seen;
  logic       stable;
  logic       err_sticky;
  logic [7:0] phase_cnt;
  logic [7:0] interval;
  logic [7:0] phase;
  logic [3:0] good_cnt;
  logic [3:0] good_next;
  logic [4:0] err_cnt;
  logic       period_ok;
  logic       period_err;
  logic       timeout;
  logic       err_event;

  assign period_ok  = (interval == PERIOD);
  assign period_err = edge_q & seen & ~period_ok;
  // Interval saturates at 255, so a missing SYSREF times out exactly once per gap.
  assign timeout    = ~edge_q & seen & (interval == 8'd254);
  assign err_event  = period_err | timeout;
  assign good_next  = (good_cnt == 4'd15) ? 4'd15 : good_cnt + 4'd1;

  always_ff @(posedge aclk_i) begin
    if (!aclk_rstn_i) begin
      s_q        <= 1'b0;
      edge_q     <= 1'b0;
      armed      <= 1'b0;
      seen       <= 1'b0;
      stable     <= 1'b0;
      err_sticky <= 1'b0;
      phase_cnt  <= 8'd0;
      interval   <= 8'd0;
      phase      <= 8'd0;
      good_cnt   <= 4'd0;
      err_cnt    <= 5'd0;
    end else begin
      s_q    <= sysref_i;
      edge_q <= sysref_i & ~s_q;

      // An armed edge restarts the counter so that edge itself reads as phase 0.
      if (edge_q && armed)
        phase_cnt <= 8'd1;
      else if (phase_cnt == CNT_LAST)
        phase_cnt <= 8'd0;
      else
        phase_cnt <= phase_cnt + 8'd1;

      if (edge_q)
        interval <= 8'd1;
      else if (interval != 8'd255)
        interval <= interval + 8'd1;

      if (edge_q) begin
        seen  <= 1'b1;
        phase <= armed ? 8'd0 : phase_cnt;
      end

      if (edge_q && seen && period_ok) begin
        good_cnt <= good_next;
        if (good_next >= LOCK)
          stable <= 1'b1;
      end

      // An error event in the same cycle as clear_i wins and restarts the count at 1.
      if (err_event) begin
        err_sticky <= 1'b1;
        err_cnt    <= clear_i ? 5'd1 : ((err_cnt == 5'd31) ? 5'd31 : err_cnt + 5'd1);
        good_cnt   <= 4'd0;
        stable     <= 1'b0;
      end else if (clear_i) begin
        err_sticky <= 1'b0;
        err_cnt    <= 5'd0;
      end

      if (align_i)
        armed <= 1'b1;
      else if (edge_q)
        armed <= 1'b0;
    end
  end

  assign sysref_phase_o = {seen, stable, err_sticky, err_cnt, phase};
  assign sysref_edge_o  = edge_q;

endmodule

// File: tb/tb_sysref_phase_mon.sv
// Bench for sysref_phase_mon: directed and randomized SYSREF streams compared
// every cycle against a cycle-index based reference model.
module tb_sysref_phase_mon;
  localparam int P    = 48;
  localparam int LOCK = 4;

  logic        aclk_i = 1'b0;
  logic        aclk_rstn_i = 1'b0;
  logic        sysref_i = 1'b0;
  logic        align_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [15:0] sysref_phase_o;
  logic        sysref_edge_o;

  int n_checks = 0;
  int n_errs   = 0;

  sysref_phase_mon #(.SYSREF_PERIOD(P), .LOCK_COUNT(LOCK)) dut (
    .aclk_i         (aclk_i),
    .aclk_rstn_i    (aclk_rstn_i),
    .sysref_i       (sysref_i),
    .align_i        (align_i),
    .clear_i        (clear_i),
    .sysref_phase_o (sysref_phase_o),
    .sysref_edge_o  (sysref_edge_o)
  );

  always #5 aclk_i = ~aclk_i;

  // Reference model: mk counts clock edges since reset; the phase of a rise
  // sampled at edge r is (r - origin) mod P, and the spacing of two detected
  // edges is the difference of their edge indices.
  int  mk;
  int  m_origin;
  int  m_last_e;
  int  m_phase;
  int  m_cnt;
  int  m_good;
  bit  m_prev_sys;
  bit  m_rise;
  bit  m_seen;
  bit  m_stable;
  bit  m_sticky;
  bit  m_armed;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [15:0] exp_word();
    logic [4:0] c;
    logic [7:0] ph;
    c  = 5'(m_cnt);
    ph = 8'(m_phase);
    return {m_seen, m_stable, m_sticky, c, ph};
  endfunction

  task automatic model_step(input bit rstn, input bit sys, input bit aln, input bit clr);
    bit e_now;
    bit perr;
    bit tout;
    int ival;
    if (!rstn) begin
      mk = 0; m_origin = 0; m_last_e = 0; m_phase = 0; m_cnt = 0; m_good = 0;
      m_prev_sys = 0; m_rise = 0; m_seen = 0; m_stable = 0; m_sticky = 0; m_armed = 0;
      return;
    end
    mk++;
    e_now = m_rise;
    ival  = min_i(mk - m_last_e, 255);
    perr  = e_now && m_seen && (ival != P);
    tout  = !e_now && m_seen && (ival == 254);
    if (e_now) begin
      if (m_armed) begin
        m_origin = mk - 1;
        m_phase  = 0;
      end else begin
        m_phase = (mk - 1 - m_origin) % P;
      end
      if (m_seen && !perr) begin
        m_good = min_i(m_good + 1, 15);
        if (m_good >= LOCK) m_stable = 1;
      end
      m_seen   = 1;
      m_last_e = mk;
    end
    if (perr || tout) begin
      m_sticky = 1;
      m_cnt    = clr ? 1 : min_i(m_cnt + 1, 31);
      m_good   = 0;
      m_stable = 0;
    end else if (clr) begin
      m_sticky = 0;
      m_cnt    = 0;
    end
    if (aln) m_armed = 1;
    else if (e_now) m_armed = 0;
    m_rise     = sys && !m_prev_sys;
    m_prev_sys = sys;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, mk);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare at the falling edge.
  task automatic tick(input bit rstn, input bit sys, input bit aln, input bit clr);
    aclk_rstn_i = rstn;
    sysref_i    = sys;
    align_i     = aln;
    clear_i     = clr;
    model_step(rstn, sys, aln, clr);
    @(negedge aclk_i);
    check("edge", {15'd0, sysref_edge_o}, {15'd0, m_rise});
    check("word", sysref_phase_o, exp_word());
  endtask

  // n rising edges spaced per cycles with random high width; align/clear
  // pulse at the given tick of the first period (-1 for none).
  task automatic stream(input int n, input int per, input int align_at, input int clear_at);
    int w;
    for (int e = 0; e < n; e++) begin
      w = $urandom_range(1, per - 1);
      for (int i = 0; i < per; i++)
        tick(1'b1, i < w, (e == 0) && (i == align_at), (e == 0) && (i == clear_at));
    end
  endtask

  initial begin
    int per;
    int al;
    int cl;
    logic [15:0] w0;

    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_word", sysref_phase_o, 16'h0000);

    for (int i = 0; i < 300; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("idle_no_timeout", sysref_phase_o, 16'h0000);

    while (((mk + 1) % P) != 17) tick(1'b1, 1'b0, 1'b0, 1'b0);
    stream(5, P, -1, -1);
    check("locked_c011", sysref_phase_o, 16'hC011);

    stream(1, 47, -1, -1);
    stream(1, P, -1, -1);
    w0 = sysref_phase_o;
    check("short_period_bits", {10'd0, w0[14:8]}, {10'd0, 7'b0_1_00001});
    stream(4, P, -1, -1);
    w0 = sysref_phase_o;
    check("relock_stable", {15'd0, w0[14]}, 16'd1);

    stream(1, P, -1, 10);
    w0 = sysref_phase_o;
    check("clear_alone", {10'd0, w0[13:8]}, 16'd0);

    stream(4, P, 24, -1);
    w0 = sysref_phase_o;
    check("align_phase_zero", {8'd0, w0[7:0]}, 16'd0);
    check("align_no_error", {10'd0, w0[14:8]}, {9'd0, 7'b1_0_00000});

    for (int i = 0; i < 300; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    w0 = sysref_phase_o;
    check("timeout_once", {8'd0, w0[15:8]}, {8'd0, 8'b1_0_1_00001});

    for (int i = 0; i < 40; i++) stream(1, $urandom_range(3, 40), -1, -1);
    w0 = sysref_phase_o;
    check("err_cnt_sat", {11'd0, w0[12:8]}, 16'd31);

    stream(1, 20, -1, 1);
    w0 = sysref_phase_o;
    check("clear_vs_error", {10'd0, w0[13:8]}, {10'd0, 6'b1_00001});

    stream(2, P, -1, -1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("mid_reset_word", sysref_phase_o, 16'h0000);
    stream(1, 30, -1, -1);
    w0 = sysref_phase_o;
    check("first_edge_after_reset", {13'd0, w0[15], w0[13], w0[8]}, {13'd0, 3'b100});

    for (int k = 0; k < 30; k++) begin
      per = ($urandom_range(0, 3) != 0) ? P : $urandom_range(2, 254);
      al  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, per - 1) : -1;
      cl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, per - 1) : -1;
      stream(1, per, al, cl);
    end
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
